// File: rtl/control_matrix.sv
`default_nettype none
// control_matrix: single-cycle 4 x 8-bit register CPU with stalling LOAD and a one-cycle STORE strobe.
// Define CONTROL_MATRIX_COND_BRANCH_EN to add the Z/C flags, CMP, JZ, JNZ and JC.
module control_matrix #(
    parameter logic [15:0] RESET_IP = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [25:0] instruction,
    output logic [15:0] instructionPointer,
    input  logic [15:0] addressIn,
    input  logic [7:0]  valueIn,
    output logic [15:0] addressOut,
    output logic [7:0]  valueOut,
    output logic        writeStrobe
);

    localparam logic [4:0] OP_HALT  = 5'd1;
    localparam logic [4:0] OP_LDI   = 5'd2;
    localparam logic [4:0] OP_ADD   = 5'd3;
    localparam logic [4:0] OP_SUB   = 5'd4;
    localparam logic [4:0] OP_AND   = 5'd5;
    localparam logic [4:0] OP_OR    = 5'd6;
    localparam logic [4:0] OP_LOAD  = 5'd8;
    localparam logic [4:0] OP_STORE = 5'd9;
    localparam logic [4:0] OP_JMP   = 5'd10;
`ifdef CONTROL_MATRIX_COND_BRANCH_EN
    localparam logic [4:0] OP_CMP   = 5'd7;
    localparam logic [4:0] OP_JZ    = 5'd11;
    localparam logic [4:0] OP_JNZ   = 5'd12;
    localparam logic [4:0] OP_JC    = 5'd13;
`endif

    logic [4:0]  op;
    logic [7:0]  imm8;
    logic [1:0]  mreg, idx_a, idx_b, idx_d;
    logic [15:0] addr16;

    assign op     = instruction[25:21];
    assign imm8   = instruction[20:13];
    assign mreg   = instruction[17:16];
    assign addr16 = instruction[15:0];
    assign idx_b  = instruction[5:4];
    assign idx_a  = instruction[3:2];
    assign idx_d  = instruction[1:0];

    logic [7:0]  registerA, registerB, registerC, registerD;
    logic [15:0] ip_q, ip_d, addr_q, addr_d;
    logic [7:0]  val_q, val_d;
    logic        strobe_q, strobe_d;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [7:0]  wr_val;
    logic [7:0]  opa, opb, mval, and_r, or_r;

    function automatic logic [7:0] rsel(input logic [1:0] idx, input logic [7:0] ra,
                                        input logic [7:0] rb, input logic [7:0] rc,
                                        input logic [7:0] rd);
        case (idx)
            2'd0:    rsel = ra;
            2'd1:    rsel = rb;
            2'd2:    rsel = rc;
            default: rsel = rd;
        endcase
    endfunction

    assign opa   = rsel(idx_a, registerA, registerB, registerC, registerD);
    assign opb   = rsel(idx_b, registerA, registerB, registerC, registerD);
    assign mval  = rsel(mreg,  registerA, registerB, registerC, registerD);
    assign and_r = opa & opb;
    assign or_r  = opa | opb;

`ifdef CONTROL_MATRIX_COND_BRANCH_EN
    logic       z_q, z_d, c_q, c_d;
    logic [8:0] sum, diff;
    // Bit 8 of the zero-extended difference is the borrow (opa < opb).
    assign sum  = {1'b0, opa} + {1'b0, opb};
    assign diff = {1'b0, opa} - {1'b0, opb};
`else
    logic [7:0] sum, diff;
    assign sum  = opa + opb;
    assign diff = opa - opb;
`endif

    always_comb begin
        ip_d     = ip_q + 16'd1;
        addr_d   = addr_q;
        val_d    = val_q;
        strobe_d = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = idx_d;
        wr_val   = sum[7:0];
`ifdef CONTROL_MATRIX_COND_BRANCH_EN
        z_d      = z_q;
        c_d      = c_q;
`endif
        case (op)
            OP_HALT: ip_d = ip_q;
            OP_LDI: begin
                wr_en  = 1'b1;
                wr_val = imm8;
            end
            OP_ADD: begin
                wr_en  = 1'b1;
                wr_val = sum[7:0];
`ifdef CONTROL_MATRIX_COND_BRANCH_EN
                z_d    = (sum[7:0] == 8'd0);
                c_d    = sum[8];
`endif
            end
            OP_SUB: begin
                wr_en  = 1'b1;
                wr_val = diff[7:0];
`ifdef CONTROL_MATRIX_COND_BRANCH_EN
                z_d    = (diff[7:0] == 8'd0);
                c_d    = diff[8];
`endif
            end
            OP_AND: begin
                wr_en  = 1'b1;
                wr_val = and_r;
`ifdef CONTROL_MATRIX_COND_BRANCH_EN
                z_d    = (and_r == 8'd0);
                c_d    = 1'b0;
`endif
            end
            OP_OR: begin
                wr_en  = 1'b1;
                wr_val = or_r;
`ifdef CONTROL_MATRIX_COND_BRANCH_EN
                z_d    = (or_r == 8'd0);
                c_d    = 1'b0;
`endif
            end
`ifdef CONTROL_MATRIX_COND_BRANCH_EN
            OP_CMP: begin
                z_d = (diff[7:0] == 8'd0);
                c_d = diff[8];
            end
            OP_JZ:  if (z_q)  ip_d = addr16;
            OP_JNZ: if (!z_q) ip_d = addr16;
            OP_JC:  if (c_q)  ip_d = addr16;
`endif
            OP_LOAD: begin
                addr_d = addr16;
                // Stall on the same instruction until the memory tag matches.
                if (addressIn == addr16) begin
                    wr_en  = 1'b1;
                    wr_idx = mreg;
                    wr_val = valueIn;
                end else begin
                    ip_d = ip_q;
                end
            end
            OP_STORE: begin
                addr_d   = addr16;
                val_d    = mval;
                strobe_d = 1'b1;
            end
            OP_JMP:  ip_d = addr16;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ip_q      <= RESET_IP;
            addr_q    <= 16'd0;
            val_q     <= 8'd0;
            strobe_q  <= 1'b0;
            registerA <= 8'd0;
            registerB <= 8'd0;
            registerC <= 8'd0;
            registerD <= 8'd0;
        end else begin
            ip_q     <= ip_d;
            addr_q   <= addr_d;
            val_q    <= val_d;
            strobe_q <= strobe_d;
            if (wr_en) begin
                case (wr_idx)
                    2'd0:    registerA <= wr_val;
                    2'd1:    registerB <= wr_val;
                    2'd2:    registerC <= wr_val;
                    default: registerD <= wr_val;
                endcase
            end
        end
    end

`ifdef CONTROL_MATRIX_COND_BRANCH_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            z_q <= 1'b0;
            c_q <= 1'b0;
        end else begin
            z_q <= z_d;
            c_q <= c_d;
        end
    end
`endif

    assign instructionPointer = ip_q;
    assign addressOut         = addr_q;
    assign valueOut           = val_q;
    assign writeStrobe        = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_control_matrix.sv
`default_nettype none
// tb_control_matrix: directed programs plus randomized instructions, each edge compared to a behavioural CPU model.
module tb_control_matrix;

`ifdef CONTROL_MATRIX_COND_BRANCH_EN
    localparam bit COND = 1'b1;
`else
    localparam bit COND = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [25:0] instruction;
    logic [15:0] instructionPointer;
    logic [15:0] addressIn = 16'd0;
    logic [7:0]  valueIn = 8'd0;
    logic [15:0] addressOut;
    logic [7:0]  valueOut;
    logic        writeStrobe;

    logic [25:0] prog [0:65535];
    int vectors = 0;
    int errs = 0;

    int m_r[4];
    int m_ip, m_z, m_c, m_ao, m_vo, m_ws;

    assign instruction = prog[instructionPointer];

    control_matrix #(.RESET_IP(16'h0000)) dut (
        .clock              (clock),
        .reset              (reset),
        .instruction        (instruction),
        .instructionPointer (instructionPointer),
        .addressIn          (addressIn),
        .valueIn            (valueIn),
        .addressOut         (addressOut),
        .valueOut           (valueOut),
        .writeStrobe        (writeStrobe)
    );

    always #5 clock = ~clock;

    function automatic logic [25:0] f_ldi(input logic [1:0] d, input logic [7:0] imm);
        f_ldi = {5'd2, imm, 11'd0, d};
    endfunction

    function automatic logic [25:0] f_alu(input logic [4:0] op, input logic [1:0] d,
                                          input logic [1:0] a, input logic [1:0] b);
        f_alu = {op, 15'd0, b, a, d};
    endfunction

    function automatic logic [25:0] f_mem(input logic [4:0] op, input logic [1:0] mr,
                                          input logic [15:0] addr);
        f_mem = {op, 3'd0, mr, addr};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 0;
        m_ip = 0; m_z = 0; m_c = 0; m_ao = 0; m_vo = 0; m_ws = 0;
    endtask

    // Executes prog[m_ip] with the current memory inputs, as the DUT will on the next edge.
    task automatic model_step();
        logic [25:0] ins;
        int op, imm, mr, addr, a, b, d, ra, rb, res, nip;
        ins  = prog[m_ip[15:0]];
        op   = int'(ins[25:21]);
        imm  = int'(ins[20:13]);
        mr   = int'(ins[17:16]);
        addr = int'(ins[15:0]);
        b    = int'(ins[5:4]);
        a    = int'(ins[3:2]);
        d    = int'(ins[1:0]);
        ra   = m_r[a];
        rb   = m_r[b];
        nip  = (m_ip + 1) % 65536;
        m_ws = 0;
        case (op)
            1: nip = m_ip;
            2: m_r[d] = imm;
            3: begin res = ra + rb; m_r[d] = res % 256; m_c = int'(res > 255); m_z = int'(res % 256 == 0); end
            4: begin res = ra - rb; m_r[d] = (res + 256) % 256; m_c = int'(ra < rb); m_z = int'(res == 0); end
            5: begin res = ra & rb; m_r[d] = res; m_c = 0; m_z = int'(res == 0); end
            6: begin res = ra | rb; m_r[d] = res; m_c = 0; m_z = int'(res == 0); end
            7: if (COND) begin m_c = int'(ra < rb); m_z = int'(ra == rb); end
            8: begin
                m_ao = addr;
                if (int'(addressIn) == addr) m_r[mr] = int'(valueIn);
                else nip = m_ip;
            end
            9: begin m_ao = addr; m_vo = m_r[mr]; m_ws = 1; end
            10: nip = addr;
            11: if (COND && m_z == 1) nip = addr;
            12: if (COND && m_z == 0) nip = addr;
            13: if (COND && m_c == 1) nip = addr;
            default: ;
        endcase
        m_ip = nip;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ip"},  32'(instructionPointer), m_ip);
        chk({tag, ".A"},   32'(dut.registerA), m_r[0]);
        chk({tag, ".B"},   32'(dut.registerB), m_r[1]);
        chk({tag, ".C"},   32'(dut.registerC), m_r[2]);
        chk({tag, ".D"},   32'(dut.registerD), m_r[3]);
        chk({tag, ".aout"}, 32'(addressOut), m_ao);
        chk({tag, ".vout"}, 32'(valueOut), m_vo);
        chk({tag, ".wstb"}, 32'(writeStrobe), m_ws);
`ifdef CONTROL_MATRIX_COND_BRANCH_EN
        chk({tag, ".zf"},  32'(dut.z_q), m_z);
        chk({tag, ".cf"},  32'(dut.c_q), m_c);
`endif
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clock);
        #1;
        check_model(tag);
    endtask

    // Reset is raised mid-cycle and checked before any clock edge to prove it is asynchronous.
    task automatic do_reset(input string tag);
        @(negedge clock);
        reset = 1'b1;
        #1;
        model_reset();
        check_model(tag);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int op;
        logic [25:0] ins;
        for (int i = 0; i < 65536; i++) prog[i] = 26'd0;

        // Counter loop program
        prog[0] = f_ldi(2'd0, 8'd0);
        prog[1] = f_ldi(2'd1, 8'd20);
        prog[2] = f_ldi(2'd2, 8'd0);
        prog[3] = f_ldi(2'd3, 8'd1);
        prog[4] = f_alu(5'd3, 2'd0, 2'd0, 2'd3);
        prog[5] = f_alu(5'd7, 2'd0, 2'd0, 2'd1);
        prog[6] = f_mem(5'd12, 2'd0, 16'd4);
        prog[7] = f_mem(5'd1, 2'd0, 16'd0);
        do_reset("rst0");
        for (int i = 0; i < 3; i++) step("ldi");
        chk("ldi.A", 32'(dut.registerA), 0);
        chk("ldi.B", 32'(dut.registerB), 20);
        chk("ldi.C", 32'(dut.registerC), 0);
        chk("ldi.ip", 32'(instructionPointer), 3);
        step("ldiD");
`ifdef CONTROL_MATRIX_COND_BRANCH_EN
        for (int i = 0; i < 60; i++) step("loop");
        chk("loop.A", 32'(dut.registerA), 20);
`else
        for (int i = 0; i < 3; i++) step("nobr");
        chk("nobr.A", 32'(dut.registerA), 1);
`endif
        chk("loop.ip", 32'(instructionPointer), 7);
        for (int i = 0; i < 10; i++) begin
            step("halt");
            chk("halt.ip", 32'(instructionPointer), 7);
        end
        do_reset("rst_halt");
        chk("rsth.ip", 32'(instructionPointer), 0);
        chk("rsth.B", 32'(dut.registerB), 0);

        // Arithmetic, STORE, LOAD stall, IP wrap, reset during STORE
        prog[0] = f_ldi(2'd0, 8'd200);
        prog[1] = f_ldi(2'd1, 8'd100);
        prog[2] = f_alu(5'd3, 2'd2, 2'd0, 2'd1);
        prog[3] = f_alu(5'd4, 2'd2, 2'd0, 2'd0);
        prog[4] = f_ldi(2'd1, 8'd20);
        prog[5] = f_mem(5'd9, 2'd1, 16'h1234);
        prog[6] = 26'd0;
        prog[7] = f_mem(5'd8, 2'd3, 16'h0010);
        prog[8] = f_mem(5'd10, 2'd0, 16'hFFFF);
        prog[65535] = 26'd0;
        for (int i = 0; i < 3; i++) step("add");
        chk("add.C", 32'(dut.registerC), 44);
`ifdef CONTROL_MATRIX_COND_BRANCH_EN
        chk("add.cf", 32'(dut.c_q), 1);
        chk("add.zf", 32'(dut.z_q), 0);
`endif
        step("sub");
        chk("sub.C", 32'(dut.registerC), 0);
`ifdef CONTROL_MATRIX_COND_BRANCH_EN
        chk("sub.zf", 32'(dut.z_q), 1);
        chk("sub.cf", 32'(dut.c_q), 0);
`endif
        step("ldiB");
        step("store");
        chk("store.aout", 32'(addressOut), 32'h1234);
        chk("store.vout", 32'(valueOut), 20);
        chk("store.wstb", 32'(writeStrobe), 1);
        step("nop");
        chk("nop.wstb", 32'(writeStrobe), 0);
        chk("nop.aout", 32'(addressOut), 32'h1234);
        addressIn = 16'h0000;
        step("stall");
        step("stall");
        chk("stall.ip", 32'(instructionPointer), 7);
        addressIn = 16'h0010;
        valueIn   = 8'h5A;
        step("load");
        chk("load.D", 32'(dut.registerD), 32'h5A);
        chk("load.ip", 32'(instructionPointer), 8);
        step("jmp");
        step("wrap");
        chk("wrap.ip", 32'(instructionPointer), 0);
        prog[0] = f_mem(5'd9, 2'd3, 16'hABCD);
        step("store2");
        chk("store2.wstb", 32'(writeStrobe), 1);
        do_reset("rst_store");
        chk("rsts.wstb", 32'(writeStrobe), 0);
        chk("rsts.aout", 32'(addressOut), 0);

        // Randomized instructions
        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 15));
            if (op == 1) op = 3;
            if (op > 13) op = int'($urandom_range(14, 31));
            ins = 26'($urandom);
            ins[25:21] = op[4:0];
            prog[m_ip[15:0]] = ins;
            if (op == 8 && $urandom_range(0, 2) != 0) addressIn = ins[15:0];
            else addressIn = 16'($urandom);
            valueIn = 8'($urandom);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_matrix.md
CONTROL_MATRIX -- requirements
Module: control_matrix

Interface
REQ-001 Parameter: RESET_IP, 16'h0000, instructionPointer value loaded on reset.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-high.
REQ-004 instruction  input  26  instruction word addressed by instructionPointer, supplied combinationally by the environment.
REQ-005 instructionPointer  output  16  registered address of the current instruction.
REQ-006 addressIn  input  16  address tag of the data presented on valueIn.
REQ-007 valueIn  input  8  read data from external memory.
REQ-008 addressOut  output  16  registered memory address of the last LOAD/STORE.
REQ-009 valueOut  output  8  registered store data.
REQ-010 writeStrobe  output  1  high for exactly one cycle after a STORE executes.
REQ-011 Internal 8-bit registers SHALL be named registerA, registerB, registerC, registerD (index 0-3) so benches can probe them hierarchically.

Function
REQ-012 Fields: op=[25:21], imm8=[20:13], mreg=[17:16], addr16=[15:0], b=[5:4], a=[3:2], d=[1:0].
REQ-013 One instruction SHALL execute per rising edge, single-cycle, no pipeline; unless stated otherwise, instructionPointer SHALL become IP+1 (mod 2^16; 16'hFFFF wraps to 0).
REQ-014 op 0 NOP: no state change except IP+1; undefined ops 14-31 SHALL behave as NOP.
REQ-015 op 1 HALT: IP held; no other state change; only reset leaves HALT.
REQ-016 op 2 LDI: R[d]=imm8; flags unchanged.
REQ-017 op 3 ADD: R[d]=(R[a]+R[b]) mod 256; C=carry out of bit 7; Z=(result==0).
REQ-018 op 4 SUB: R[d]=(R[a]-R[b]) mod 256; C=borrow (R[a]<R[b]); Z=(result==0).
REQ-019 op 5 AND / op 6 OR: R[d]=R[a]&R[b] / R[a]|R[b]; Z updated; C cleared.
REQ-020 op 7 CMP: Z and C computed as SUB; no register write.
REQ-021 op 8 LOAD: addressOut=addr16 on the executing edge; if addressIn==addr16, R[mreg]=valueIn and IP+1; otherwise IP held (stall) and instruction re-executes next cycle.
REQ-022 op 9 STORE: addressOut=addr16, valueOut=R[mreg], writeStrobe=1 for the following cycle; otherwise writeStrobe=0.
REQ-023 op 10 JMP: IP=addr16.
REQ-024 op 11 JZ / op 12 JNZ / op 13 JC: IP=addr16 if Z==1 / Z==0 / C==1, else IP+1.
REQ-025 Source operands SHALL be read before the edge; d==a or d==b SHALL use old values.
REQ-026 addressOut/valueOut SHALL hold their values between LOAD/STORE instructions.

Reset
REQ-027 While reset is high: instructionPointer=RESET_IP, registerA-D=0, Z=C=0, addressOut=0, valueOut=0, writeStrobe=0, asynchronously and independent of clock.
REQ-028 Reset asserted mid-stall or mid-STORE SHALL abort the operation; first instruction after deassertion executes from RESET_IP on the next rising edge.

Configuration
REQ-029 Macro CONTROL_MATRIX_COND_BRANCH_EN: defined -> CMP, JZ, JNZ, JC implemented per REQ-020/024; undefined -> ops 7, 11, 12, 13 behave as NOP, Z and C flag registers are not implemented, and arithmetic results are unaffected.

Verification
REQ-030 Reset then LDI A,0; LDI B,20; LDI C,0 at IP 0-2 -> after 3 edges registerA=0, registerB=20, registerC=0, instructionPointer=3.
REQ-031 A=200, B=100, ADD d=C -> registerC=44, C=1, Z=0; SUB C=A-A -> registerC=0, Z=1, C=0.
REQ-032 Counter loop: A=0, B=20, D=1; at IP 4 ADD A=A+D, CMP A,B, JNZ 4 -> loop exits with registerA=20 after 20 iterations; IP=7.
REQ-033 STORE B to 16'h1234 with B=20 -> addressOut=16'h1234, valueOut=20, writeStrobe high one cycle; LOAD from 16'h0010 with addressIn=16'h0000 -> IP held; addressIn=16'h0010, valueIn=8'h5A -> R[mreg]=8'h5A, IP advances.
REQ-034 JMP 16'hFFFF then NOP -> IP=16'h0000; HALT -> IP constant for 10 edges; assert reset mid-HALT -> IP=RESET_IP, all registers 0.
REQ-035 Build without CONTROL_MATRIX_COND_BRANCH_EN: JNZ 4 with Z=0 -> IP=IP+1 (no branch).
